// File: rtl/rns4_mod53_to_bin_if.sv
// Handshake and data bundle for the {64,53,59,61} residue-to-binary converter.
// Carries the input tuple with in_valid/in_ready and the result with out_valid/out_ready.
// master: residue producer / result consumer side; slave: the converter.
interface rns4_mod53_to_bin_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  r64;
    logic [5:0]  r53;
    logic [5:0]  r59;
    logic [5:0]  r61;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] x_out;
    logic        out_err;

    modport master (
        output in_valid, r64, r53, r59, r61, out_ready,
        input  in_ready, out_valid, x_out, out_err
    );

    modport slave (
        input  in_valid, r64, r53, r59, r61, out_ready,
        output in_ready, out_valid, x_out, out_err
    );
endinterface

// File: rtl/rns4_mod53_to_bin.sv
// Residue-to-binary converter for moduli {64,53,59,61} (M = 12207808) using sequential mixed-radix conversion.
// Latency: result 7 edges after accept for a valid tuple, 2 edges for an out-of-range tuple; one tuple per 9 cycles max.
// Backpressure: in_ready is high only in IDLE; the result is held stable in DONE until out_valid && out_ready.
// Ports: clk, rst (async active-high), bus (slave modport): in_valid/in_ready/r64/r53/r59/r61 in,
//        out_valid/out_ready/x_out/out_err out.
module rns4_mod53_to_bin (
    input  logic                   clk,
    input  logic                   rst,
    rns4_mod53_to_bin_if.slave     bus
);

    typedef enum logic [3:0] {
        IDLE, S1, S2, S3, S4, S5, S6, S7, ERR_WAIT, ERR, DONE
    } state_t;

    state_t      state_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        out_err_q;
    logic [23:0] x_q;
    logic [5:0]  a1_q, a2_q, a3_q, a4_q;
    logic [5:0]  r53_q, r59_q, r61_q;
    logic [5:0]  t_q, u_q;

    logic [5:0]  res_d;
    logic [23:0] x_d;

    // ((a - b) mod m) * k mod m. b may be up to 63 (a1 = r64 exceeds 53),
    // so 2m is added before reducing to keep the difference non-negative.
    function automatic logic [5:0] step(input logic [5:0] a, input logic [5:0] b,
                                        input logic [6:0] m, input logic [5:0] k);
        logic [11:0] m12;
        logic [11:0] d;
        m12 = {5'd0, m};
        d   = (12'(a) + (m12 << 1) - 12'(b)) % m12;
        return 6'((d * 12'(k)) % m12);
    endfunction

    always_comb begin
        res_d = '0;
        case (state_q)
            S1:      res_d = step(r53_q, a1_q, 7'd53, 6'd29);
            S2:      res_d = step(r59_q, a1_q, 7'd59, 6'd12);
            S3:      res_d = step(t_q,   a2_q, 7'd59, 6'd49);
            S4:      res_d = step(r61_q, a1_q, 7'd61, 6'd41);
            S5:      res_d = step(u_q,   a2_q, 7'd61, 6'd38);
            S6:      res_d = step(u_q,   a3_q, 7'd61, 6'd30);
            default: res_d = '0;
        endcase
        // Maximum is exactly M-1, so 24 bits never truncate.
        x_d = ((24'(a4_q) * 24'd59 + 24'(a3_q)) * 24'd53 + 24'(a2_q)) * 24'd64 + 24'(a1_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            x_q         <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            r53_q       <= '0;
            r59_q       <= '0;
            r61_q       <= '0;
            t_q         <= '0;
            u_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a1_q       <= bus.r64;
                        r53_q      <= bus.r53;
                        r59_q      <= bus.r59;
                        r61_q      <= bus.r61;
                        in_ready_q <= 1'b0;
                        if (bus.r53 > 6'd52 || bus.r59 > 6'd58 || bus.r61 > 6'd60)
                            state_q <= ERR_WAIT;
                        else
                            state_q <= S1;
                    end
                end
                S1: begin a2_q <= res_d; state_q <= S2; end
                S2: begin t_q  <= res_d; state_q <= S3; end
                S3: begin a3_q <= res_d; state_q <= S4; end
                S4: begin u_q  <= res_d; state_q <= S5; end
                S5: begin u_q  <= res_d; state_q <= S6; end
                S6: begin a4_q <= res_d; state_q <= S7; end
                S7: begin
                    x_q         <= x_d;
                    out_err_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                // Bad tuples report on the second edge after accept; this
                // cycle only spaces the error response to that point.
                ERR_WAIT: state_q <= ERR;
                ERR: begin
                    x_q         <= '0;
                    out_err_q   <= 1'b1;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = x_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_rns4_mod53_to_bin.sv
module tb_rns4_mod53_to_bin;

    localparam int M = 12207808;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    rns4_mod53_to_bin_if bus ();

    rns4_mod53_to_bin dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Sends one tuple, checks accept, latency, result, handshake and return to IDLE.
    task automatic convert(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                           input logic [5:0] d, input logic [23:0] exp_x, input logic exp_err,
                           input int exp_lat, input string tag);
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.r64 = a; bus.r53 = b; bus.r59 = c; bus.r61 = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.r64 = 6'($urandom); bus.r53 = 6'($urandom);
        bus.r59 = 6'($urandom); bus.r61 = 6'($urandom);
        n = 0;
        while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_x"}, {8'd0, bus.x_out}, {8'd0, exp_x});
        chk({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        chk({tag, "_hs_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_hs_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [23:0] xr;
        logic [23:0] hold_x;
        total  = 0;
        passed = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.r64 = '0; bus.r53 = '0; bus.r59 = '0; bus.r61 = '0;
        rst = 1'b1;
        #22;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_x",         {8'd0, bus.x_out},      32'd0);
        chk("rst_err",       {31'd0, bus.out_err},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed valid tuples.
        convert(6'd0,  6'd0,  6'd0,  6'd0,  24'd0,        1'b0, 7, "zero");
        convert(6'd40, 6'd46, 6'd56, 6'd24, 24'd1000,     1'b0, 7, "x1000");
        convert(6'd63, 6'd52, 6'd58, 6'd60, 24'd12207807, 1'b0, 7, "max");
        convert(6'd1,  6'd1,  6'd1,  6'd1,  24'd1,        1'b0, 7, "one");
        convert(6'd57, 6'd49, 6'd14, 6'd23, 24'd12345,    1'b0, 7, "x12345");

        // Random X: residues from the bench, expected value is X itself.
        for (int i = 0; i < 200; i++) begin
            xr = 24'($urandom_range(M - 1));
            convert(6'(xr % 64), 6'(xr % 53), 6'(xr % 59), 6'(xr % 61), xr, 1'b0, 7, "rand");
        end

        // Out-of-range residues.
        convert(6'd5, 6'd53, 6'd0,  6'd0,  24'd0, 1'b1, 2, "err53");
        convert(6'd5, 6'd0,  6'd59, 6'd0,  24'd0, 1'b1, 2, "err59");
        convert(6'd5, 6'd0,  6'd0,  6'd63, 24'd0, 1'b1, 2, "err61");
        convert(6'd40, 6'd46, 6'd56, 6'd24, 24'd1000, 1'b0, 7, "after_err");

        // Backpressure: hold result for 5 cycles while driving junk inputs.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.r64 = 6'd57; bus.r53 = 6'd49; bus.r59 = 6'd14; bus.r61 = 6'd23;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 20 && !bus.out_valid; n++) begin @(posedge clk); #1; end
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        hold_x = 24'd12345;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.r64 = 6'($urandom); bus.r53 = 6'($urandom % 53);
            bus.r59 = 6'($urandom % 59); bus.r61 = 6'($urandom % 61);
            @(posedge clk); #1;
            chk("bp_hold_x",     {8'd0, bus.x_out},      {8'd0, hold_x});
            chk("bp_hold_err",   {31'd0, bus.out_err},   32'd0);
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_in_ready",   {31'd0, bus.in_ready},  32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid",    {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, bus.in_ready},  32'd1);
        chk("bp_retain_x",         {8'd0, bus.x_out},      {8'd0, hold_x});
        @(posedge clk); #1;
        chk("bp_no_new_valid", {31'd0, bus.out_valid}, 32'd0);

        // Async reset in the middle of a conversion (state S4).
        bus.in_valid = 1'b1;
        bus.r64 = 6'd63; bus.r53 = 6'd52; bus.r59 = 6'd58; bus.r61 = 6'd60;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_x",         {8'd0, bus.x_out},      32'd0);
        chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        convert(6'd40, 6'd46, 6'd56, 6'd24, 24'd1000, 1'b0, 7, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
